add_sub_serial_param: RTL and testbench

Parametrised digit-serial adder/subtractor for datapath blocks that trade latency for area. Each operation accepts two WIDTH-bit operands over a valid/ready handshake and processes DIGIT bits per cycle. It returns the sum or difference, carry-out and signed overflow over a second valid/ready handshake. An optional key-locked control path inserts decoy states and corrupts results under a wrong key.

---
 rtl/add_serial_pkg.sv | 22 ++
 rtl/add_sub_serial_param_digit_adder.sv | 24 ++
 rtl/add_sub_serial_param.sv | 138 +++++++++++++
 tb/tb_add_sub_serial_param.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_serial_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// The decoy states D0..D2 are only reachable when ADD_SERIAL_OBFS_EN is defined.
package add_serial_pkg;

  localparam int unsigned STATE_W = 3;

  // Encodings 6..7 are unused and fall back to IDLE in the FSM default branch.
  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    DONE = 3'd2,
    D0   = 3'd3,
    D1   = 3'd4,
    D2   = 3'd5
  } state_e;

  // Digit counter width: max(1, clog2(ndig)).
  function automatic int unsigned cnt_width(input int unsigned ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/add_sub_serial_param_digit_adder.sv
// Combinational DIGIT-wide adder with carry-in; also exposes the carry into the MSB
// so the caller can form two's-complement overflow as cmsb ^ cout.
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] s_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [DIGIT:0] full;

  // Ripple sum of the digit; carry into the MSB recovered from a^b^s at the top bit.
  always_comb begin
    full   = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT{1'b0}}, cin_i};
    s_o    = full[DIGIT-1:0];
    cout_o = full[DIGIT];
    cmsb_o = a_i[DIGIT-1] ^ b_i[DIGIT-1] ^ full[DIGIT-1];
  end

endmodule

// File: rtl/add_sub_serial_param.sv
// Digit-serial adder/subtractor: accepts two WIDTH-bit operands, processes DIGIT
// bits per cycle, returns sum, carry-out and signed overflow over valid/ready.
// Optional key-locked decoy path enabled by defining ADD_SERIAL_OBFS_EN.
module add_sub_serial_param
  import add_serial_pkg::*;
#(
  parameter int unsigned         WIDTH   = 16,
  parameter int unsigned         DIGIT   = 4,
  parameter int unsigned         KEY_W   = 8,
  parameter logic [KEY_W-1:0]    KEY_VAL = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
`ifdef ADD_SERIAL_OBFS_EN
  ,
  input  logic [KEY_W-1:0] key
`endif
);

  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned CNT_W = cnt_width(NDIG);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  logic [DIGIT-1:0]       dig_s;
  logic                   dig_c;
  logic                   dig_cmsb;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic                   key_ok;
  logic                   last_dig;

  // Current low digit of both operands through the shared digit adder.
  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .a_i    (a_q[DIGIT-1:0]),
    .b_i    (b_q[DIGIT-1:0]),
    .cin_i  (carry_q),
    .s_o    (dig_s),
    .cout_o (dig_c),
    .cmsb_o (dig_cmsb)
  );

  // New digit enters at the top of the result; the concatenation also covers DIGIT==WIDTH.
  assign sum_cat  = {dig_s, sum_q};
  assign last_dig = (cnt_q == CNT_W'(NDIG - 1));

`ifdef ADD_SERIAL_OBFS_EN
  // Key is only meaningful at the operand transfer edge.
  assign key_ok = (key == KEY_VAL);
`else
  // KEY_VAL stays in the parameter list so both builds share one interface; folds to 1.
  assign key_ok = 1'b1 | (|KEY_VAL);
`endif

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Control FSM plus operand/result shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            sum_q   <= '0;
`ifdef ADD_SERIAL_OBFS_EN
            state_q <= key_ok ? RUN : D0;
`else
            state_q <= key_ok ? RUN : IDLE;
`endif
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          sum_q   <= sum_cat[WIDTH+DIGIT-1:DIGIT];
          carry_q <= dig_c;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_dig) begin
            cout_q  <= dig_c;
            ovf_q   <= dig_cmsb ^ dig_c;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
`ifdef ADD_SERIAL_OBFS_EN
        D0: state_q <= D1;
        D1: state_q <= D2;
        // carry_q still holds sub here, so inverting it yields ~sub and skews the result by one.
        D2: begin
          carry_q <= ~carry_q;
          state_q <= RUN;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_serial_param.sv
// Scoreboard bench for add_sub_serial_param (16/4 instance and 8/8 instance).
// Decoy-path vectors compile in only when ADD_SERIAL_OBFS_EN is defined.
module tb_add_sub_serial_param;
  import add_serial_pkg::*;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          t;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  logic        in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] sum;
  logic [7:0]  key = 8'hA5;

  logic        in_valid8 = 1'b0, sub8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, cout8, ovf8;
  logic [7:0]  sum8;
  logic [7:0]  key8 = 8'hA5;

  exp_t q16[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_sub_serial_param #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
`ifdef ADD_SERIAL_OBFS_EN
    , .key(key)
`endif
  );

  add_sub_serial_param #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
`ifdef ADD_SERIAL_OBFS_EN
    , .key(key8)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor for the 16-bit instance.
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (q16.size() == 0) chk("unexpected_out_valid16", 32'(out_valid), 32'd0);
        else if (q16[0].lat != 0) chk("latency16", 32'(cyc - q16[0].t + 1), 32'(q16[0].lat));
      end
      if (out_valid) chk("in_ready_in_done16", 32'(in_ready), 32'd0);
      if (out_valid && out_ready && q16.size() > 0) begin
        e = q16.pop_front();
        chk("sum16", 32'(sum), 32'(e.s));
        chk("cout16", 32'(cout), 32'(e.c));
        chk("ovf16", 32'(ovf), 32'(e.o));
      end
      ov_prev = out_valid;
    end
  end

  // Monitor for the 8-bit single-digit instance.
  logic ov8_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      ov8_prev = 1'b0;
    end else begin
      if (out_valid8 && !ov8_prev) begin
        if (q8.size() == 0) chk("unexpected_out_valid8", 32'(out_valid8), 32'd0);
        else if (q8[0].lat != 0) chk("latency8", 32'(cyc - q8[0].t + 1), 32'(q8[0].lat));
      end
      if (out_valid8 && out_ready8 && q8.size() > 0) begin
        e = q8.pop_front();
        chk("sum8", 32'(sum8), 32'(e.s));
        chk("cout8", 32'(cout8), 32'(e.c));
        chk("ovf8", 32'(ovf8), 32'(e.o));
      end
      ov8_prev = out_valid8;
    end
  end

  task automatic do_op(input logic [15:0] ai, input logic [15:0] bi, input logic si,
                       input logic [15:0] es, input logic ec, input logic eo,
                       input int lat, input bit push, output int t_x);
    exp_t e;
    bit   ok = 1'b0;
    a = ai; b = bi; sub = si; in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("in_ready_timeout16", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      t_x = -1;
      return;
    end
    @(posedge clk); #1;
    t_x = cyc;
    in_valid = 1'b0;
    if (push) begin
      e.s = es; e.c = ec; e.o = eo; e.t = t_x; e.lat = lat;
      q16.push_back(e);
    end
  endtask

  task automatic do_op8(input logic [7:0] ai, input logic [7:0] bi, input logic si,
                        input logic [7:0] es, input logic ec, input logic eo, input int lat);
    exp_t e;
    bit   ok = 1'b0;
    a8 = ai; b8 = bi; sub8 = si; in_valid8 = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready8) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("in_ready_timeout8", 32'(in_ready8), 32'd1);
      in_valid8 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    e.s = {8'h00, es}; e.c = ec; e.o = eo; e.t = cyc; e.lat = lat;
    q8.push_back(e);
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (q16.size() == 0 && q8.size() == 0 && !out_valid && !out_valid8) break;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t1, t2, td;
    bit  seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_sum", 32'(sum), 32'd0);
    chk("post_rst_cout", 32'(cout), 32'd0);
    chk("post_rst_ovf", 32'(ovf), 32'd0);

    // Basic vectors; latency counted inclusive of the transfer edge.
    do_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 5, 1'b1, t1);
    drain();
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 5, 1'b1, t1);
    do_op(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 5, 1'b1, t1);
    do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 5, 1'b1, t1);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 5, 1'b1, t1);
    do_op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 5, 1'b1, t1);
    drain();

    // Single-digit instance with consumer stall.
    out_ready8 = 1'b0;
    do_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 2);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid8) begin seen = 1'b1; break; end
    end
    chk("out_valid8_seen", 32'(seen), 32'd1);
    in_valid8 = 1'b1; a8 = 8'h10; b8 = 8'h10;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("hold_sum8", 32'(sum8), 32'd0);
      chk("hold_cout8", 32'(cout8), 32'd1);
      chk("hold_in_ready8", 32'(in_ready8), 32'd0);
      chk("hold_out_valid8", 32'(out_valid8), 32'd1);
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("after_hold_in_ready8", 32'(in_ready8), 32'd1);
    chk("after_hold_out_valid8", 32'(out_valid8), 32'd0);
    chk("after_hold_q8_empty", 32'(q8.size()), 32'd0);
    @(posedge clk); #1;

    // Reset during the third digit discards the operation.
    do_op(16'hABCD, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, t1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_rst_sum", 32'(sum), 32'd0);
    chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    do_op(16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 5, 1'b1, t1);
    drain();

    // Back-to-back with consumer always ready: one transfer every NDIG+2 edges.
    do_op(16'h0101, 16'h0202, 1'b0, 16'h0303, 1'b0, 1'b0, 5, 1'b1, t1);
    do_op(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 5, 1'b1, t2);
    chk("b2b_spacing", 32'(t2 - t1), 32'd6);
    drain();

`ifdef ADD_SERIAL_OBFS_EN
    key = 8'hA5;
    do_op(16'h0010, 16'h0001, 1'b0, 16'h0011, 1'b0, 1'b0, 5, 1'b1, t1);
    drain();
    key = 8'h00;
    do_op(16'h0010, 16'h0001, 1'b0, 16'h0012, 1'b0, 1'b0, 8, 1'b1, t1);
    key = 8'hA5;
    chk("decoy_D0", 32'(dut.state_q), 32'(D0));
    chk("decoy_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("decoy_D1", 32'(dut.state_q), 32'(D1));
    @(posedge clk); #1;
    chk("decoy_D2", 32'(dut.state_q), 32'(D2));
    @(posedge clk); #1;
    chk("decoy_RUN", 32'(dut.state_q), 32'(RUN));
    drain();
    key = 8'h3C;
    do_op(16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b1, 1'b0, 8, 1'b1, td);
    key = 8'hA5;
    drain();
`endif

    chk("q16_empty", 32'(q16.size()), 32'd0);
    chk("q8_empty", 32'(q8.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
